// File: rtl/mux151_scan_ctrl.sv
// Scan controller for an IC74HC151 8:1 mux: steps the select lines, waits a settle
// time per channel, samples Y and publishes the assembled word with a done pulse.
module mux151_scan_ctrl #(
  parameter int DATA_IN = 8,
  parameter int SEL_W   = 3,
  parameter int SETTLE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic               y_in,
  output logic [SEL_W-1:0]   sel,
  output logic               mux_e,
  output logic               busy,
  output logic [DATA_IN-1:0] data_out,
  output logic               done
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic               mux_e_q;
  logic               busy_q;
  logic               done_q;
  logic [DATA_IN-1:0] data_q;
  logic [DATA_IN-1:0] cap_q;
  logic [DATA_IN-1:0] cap_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               sample_edge;
  logic               last_ch;

  assign sample_edge = (cnt_q == CNT_W'(SETTLE - 1));
  assign last_ch     = (sel_q == SEL_W'(DATA_IN - 1));

  // Capture word including the bit sampled on the current edge, so the final
  // channel lands in data_out on the same edge it is sampled.
  always_comb begin
    cap_d        = cap_q;
    cap_d[sel_q] = y_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mux_e_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q <= SCAN;
            sel_q   <= '0;
            mux_e_q <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SCAN: begin
          if (abort) begin
            state_q <= IDLE;
            sel_q   <= '0;
            mux_e_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (sample_edge) begin
            cnt_q <= '0;
            cap_q <= cap_d;
            if (!last_ch) begin
              sel_q <= sel_q + SEL_W'(1);
            end else begin
              data_q <= cap_d;
              done_q <= 1'b1;
              sel_q  <= '0;
              if (!cont) begin
                state_q <= IDLE;
                mux_e_q <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel      = sel_q;
  assign mux_e    = mux_e_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_mux151_scan_ctrl.sv
// Directed bench for mux151_scan_ctrl: default build plus a SETTLE=1 build,
// each driven by a behavioural 74HC151 model (Y = enabled ? din[sel] : 0).
module tb_mux151_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, cont;
  logic [7:0] din;
  logic       y_in;
  logic [2:0] sel;
  logic       mux_e, busy, done;
  logic [7:0] data_out;

  logic       start2, abort2, cont2;
  logic [7:0] din2;
  logic       y_in2;
  logic [2:0] sel2;
  logic       mux_e2, busy2, done2;
  logic [7:0] data_out2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign y_in  = mux_e  ? 1'b0 : din[sel];
  assign y_in2 = mux_e2 ? 1'b0 : din2[sel2];

  mux151_scan_ctrl #(.DATA_IN(8), .SEL_W(3), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
    .y_in(y_in), .sel(sel), .mux_e(mux_e), .busy(busy),
    .data_out(data_out), .done(done)
  );

  mux151_scan_ctrl #(.DATA_IN(8), .SEL_W(3), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .cont(cont2),
    .y_in(y_in2), .sel(sel2), .mux_e(mux_e2), .busy(busy2),
    .data_out(data_out2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start is sampled on the edge inside this task (edge k); returns at k+1ns
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset_state();
    rst_n = 1'b0;
    tick();
    total++;
    if ({sel, mux_e, busy, done, data_out} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_state got sel=%0d e=%b busy=%b done=%b data=%h want 0 1 0 0 00",
               sel, mux_e, busy, done, data_out);
    end
    total++;
    if ({sel2, mux_e2, busy2, done2, data_out2} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_state_s1 got sel=%0d e=%b busy=%b done=%b data=%h want 0 1 0 0 00",
               sel2, mux_e2, busy2, done2, data_out2);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || mux_e !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_reset got busy=%b e=%b want 0 1", busy, mux_e);
    end
    $display("reset state checked");
  endtask

  task automatic test_single_scan();
    din = 8'hA5;
    pulse_start();
    for (int j = 1; j <= 16; j++) begin
      logic [2:0] es;
      es = 3'(j / 2);
      tick();
      if (j < 16) begin
        total++;
        if (sel !== es || mux_e !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL single_step j=%0d got sel=%0d e=%b busy=%b done=%b want sel=%0d e=0 busy=1 done=0",
                   j, sel, mux_e, busy, done, es);
        end
      end else begin
        total++;
        if (done !== 1'b1 || data_out !== 8'hA5 || busy !== 1'b0 || mux_e !== 1'b1 || sel !== 3'd0) begin
          bad++;
          $display("FAIL single_done got done=%b data=%h busy=%b e=%b sel=%0d want 1 a5 0 1 0",
                   done, data_out, busy, mux_e, sel);
        end
      end
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse_width got done=%b want 0", done);
    end
    $display("single scan data_out=%h", data_out);
  endtask

  task automatic test_reset_midscan();
    din = 8'h11;
    pulse_start();
    for (int j = 0; j < 5; j++) tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({sel, mux_e, busy, done, data_out} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL async_reset got sel=%0d e=%b busy=%b done=%b data=%h want 0 1 0 0 00",
               sel, mux_e, busy, done, data_out);
    end
    rst_n = 1'b1;
    tick();
    for (int j = 0; j < 20; j++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_resume j=%0d got done=%b busy=%b want 0 0", j, done, busy);
      end
    end
    $display("mid-scan reset checked");
  endtask

  task automatic test_continuous();
    cont = 1'b1;
    din  = 8'h3C;
    pulse_start();
    for (int j = 1; j <= 48; j++) begin
      tick();
      if (j == 16 || j == 32 || j == 48) begin
        logic [7:0] ed;
        logic       eb;
        ed = (j == 16) ? 8'h3C : 8'hC3;
        eb = (j == 48) ? 1'b0 : 1'b1;
        total++;
        if (done !== 1'b1 || data_out !== ed || busy !== eb) begin
          bad++;
          $display("FAIL cont_done j=%0d got done=%b data=%h busy=%b want 1 %h %b",
                   j, done, data_out, busy, ed, eb);
        end
        if (j == 16) din = 8'hC3;
        if (j == 32) cont = 1'b0;
        $display("continuous pass ending at %0d data_out=%h", j, data_out);
      end else begin
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL cont_mid j=%0d got done=%b busy=%b want 0 1", j, done, busy);
        end
      end
    end
  endtask

  task automatic test_abort();
    din = 8'h0F;
    pulse_start();
    for (int j = 1; j <= 7; j++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || mux_e !== 1'b1 || sel !== 3'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got busy=%b e=%b sel=%0d done=%b want 0 1 0 0", busy, mux_e, sel, done);
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      total++;
      if (done !== 1'b0 || data_out !== 8'hC3) begin
        bad++;
        $display("FAIL abort_after j=%0d got done=%b data=%h want 0 c3", j, done, data_out);
      end
    end
    $display("abort mid-scan data_out=%h", data_out);

    pulse_start();
    for (int j = 1; j <= 15; j++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (done !== 1'b0 || data_out !== 8'hC3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_at_done got done=%b data=%h busy=%b want 0 c3 0", done, data_out, busy);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL abort_at_done_late got done=%b want 0", done);
    end
    $display("abort at completion data_out=%h", data_out);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || mux_e !== 1'b1) begin
      bad++;
      $display("FAIL start_abort_idle got busy=%b e=%b want 0 1", busy, mux_e);
    end
    $display("start with abort in idle checked");
  endtask

  task automatic test_back_to_back();
    din = 8'h5A;
    pulse_start();
    for (int j = 1; j <= 16; j++) begin
      start = (j == 2 || j == 9) ? 1'b1 : 1'b0;
      tick();
      start = 1'b0;
      if (j == 16) begin
        total++;
        if (done !== 1'b1 || data_out !== 8'h5A || busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_start_done got done=%b data=%h busy=%b want 1 5a 0", done, data_out, busy);
        end
      end else begin
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_start_mid j=%0d got done=%b busy=%b want 0 1", j, done, busy);
        end
      end
    end
    for (int j = 0; j < 20; j++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL busy_start_queued j=%0d got done=%b busy=%b want 0 0", j, done, busy);
      end
    end
    $display("start while busy data_out=%h", data_out);
  endtask

  task automatic test_settle1();
    din2   = 8'hFF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j < 8) begin
        total++;
        if (sel2 !== 3'(j) || done2 !== 1'b0 || busy2 !== 1'b1) begin
          bad++;
          $display("FAIL s1_step j=%0d got sel=%0d done=%b busy=%b want %0d 0 1", j, sel2, done2, busy2, j);
        end
      end else begin
        total++;
        if (done2 !== 1'b1 || data_out2 !== 8'hFF || busy2 !== 1'b0) begin
          bad++;
          $display("FAIL s1_done got done=%b data=%h busy=%b want 1 ff 0", done2, data_out2, busy2);
        end
      end
    end
    $display("settle=1 scan data_out=%h", data_out2);
  endtask

  initial begin
    start = 0; abort = 0; cont = 0; din = 8'h00;
    start2 = 0; abort2 = 0; cont2 = 0; din2 = 8'h00;
    rst_n = 1'b0;
    test_reset_state();
    test_single_scan();
    test_reset_midscan();
    test_continuous();
    test_abort();
    test_back_to_back();
    test_settle1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
